sfp_norm: RTL and testbench
===========================

Name: sfp_norm

Overview:
- Special-function stage directly downstream of the core's psum memory output.
- Consumes one row of col signed partial sums, e.g. one pmem_out read.
- Computes the row's absolute-value sum and produces it on sum_out.
- Emits the row normalised as signed fixed-point fractions psum_i / sum|psum|, with frac fractional bits, computed by one shared sequential restoring divider.

Parameters:
col, 8, number of psum lanes per row
bw_psum, 20, width of each signed psum lane
frac, 8, fractional bits of each normalised output

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous active-high reset
in  input  bw_psum*col  packed signed psums; lane i = in[bw_psum*(i+1)-1 : bw_psum*i]
in_valid  input  1  row offered on in
in_ready  output  1  block can accept a row
sum_out  output  bw_psum+4  unsigned sum of |lane| for the current row
out  output  bw_psum*col  packed signed normalised lanes, same lane order as in
out_valid  output  1  out and sum_out hold a complete result
out_ready  input  1  downstream accepts the result

Behaviour:
- Reset (async, active-high): state=IDLE; in_ready=1; out_valid=0; sum_out=0; out=0; lane index and iteration counters cleared. Assertion mid-operation aborts immediately; the partial row is discarded.
- FSM states: IDLE, SUM, DIV, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in into the row register, then go to SUM. in_ready=0 in every state other than IDLE.
- SUM (1 cycle):
  - abs_i = |lane_i|, zero-extended to bw_psum+4. -2^(bw_psum-1) maps to 2^(bw_psum-1) with no overflow.
  - sum_out <= sum of all abs_i. The width is sufficient; no saturation is needed.
  - If the sum == 0: out <= 0 and go to DONE. Otherwise set lane=0 and go to DIV.
- DIV: restoring divide of dividend abs_lane<<frac (bw_psum+frac bits) by sum_out.
  - One quotient bit per cycle; bw_psum+frac cycles per lane; MSB first; the remainder is discarded (truncation toward zero).
  - Because abs_lane <= sum, the quotient is <= 2^frac.
  - The lane result is the quotient negated if the original lane was negative, written sign-extended to bw_psum into lane slot of out.
  - After lane col-1 completes, go to DONE.
- DONE: out_valid=1. out and sum_out are held stable while out_valid && !out_ready. On out_ready, out_valid falls the next cycle and state returns to IDLE.
  - sum_out and out keep their values until the next SUM writes them.
- Latency from the accept cycle to out_valid rising:
  - 2 + col*(bw_psum+frac) cycles, which is 226 at the defaults.
  - 2 cycles for an all-zero row.
- Throughput: one row in flight. The next row can be accepted the cycle after the out handshake, since in_ready rises when the state is IDLE.
- in_valid while busy is ignored; the input is not queued. The upstream must hold in_valid until in_ready.
- out_ready while out_valid=0 has no effect.
- X-free: out lanes not yet computed read 0 during DIV.

Test Plan:
- Row [3,-1,0,0,0,0,0,0] (lane0 first) → sum_out=4; out lane0=192, lane1=-64, others 0; out_valid rises exactly 226 cycles after accept.
- All lanes 0 → sum_out=0, all out lanes 0, out_valid 2 cycles after accept; no DIV cycles.
- All lanes -524288 → sum_out=4194304; every out lane = -32 (0xFFFE0 in 20 bits).
- Row [7,0,0,0,0,0,0,0] → lane0=256 (full-scale 1.0); [1,1,1,0,...] → each nonzero lane = 85 (truncated 256/3).
- Backpressure: hold out_ready=0 for 50 cycles after out_valid → out, sum_out, out_valid stable; in_valid pulses during the hold are ignored (in_ready=0); the row accepted after release yields its own correct result.
- Assert reset at cycle 100 of DIV → out_valid=0, sum_out=0, out=0, in_ready=1 immediately; a following row [3,-1,0,...] reproduces the first scenario's results.

Source files
------------

// File: rtl/sfp_norm_if.sv
// Row-in / result-out handshake bundle for the psum normalisation stage.
// The block uses the slave modport; its upstream/downstream driver uses master.
interface sfp_norm_if #(
    parameter int col     = 8,
    parameter int bw_psum = 20
);
    logic [bw_psum*col-1:0] in;
    logic                   in_valid;
    logic                   in_ready;
    logic [bw_psum+3:0]     sum_out;
    logic [bw_psum*col-1:0] out;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, sum_out, out, out_valid
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, sum_out, out, out_valid
    );
endinterface

// File: rtl/sfp_norm.sv
// Row |psum| sum followed by per-lane psum/sum fixed-point normalisation,
// using one restoring divider shared across lanes (one quotient bit per cycle).
module sfp_norm #(
    parameter int col     = 8,
    parameter int bw_psum = 20,
    parameter int frac    = 8
) (
    input  logic        clk,
    input  logic        reset,
    sfp_norm_if.slave   bus
);
    localparam int DW     = bw_psum + frac;
    localparam int SW     = bw_psum + 4;
    localparam int LANE_W = (col > 1) ? $clog2(col) : 1;
    localparam int ITER_W = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {IDLE, SUM, DIV, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [bw_psum*col-1:0] row_reg;
    logic [bw_psum*col-1:0] out_reg;
    logic [SW-1:0]          sum_reg;
    logic [LANE_W-1:0]      lane_reg;
    logic [ITER_W-1:0]      iter_reg;
    logic [DW-1:0]          dvd_reg;
    logic [SW-1:0]          rem_reg;
    logic [bw_psum-1:0]     quot_reg;

    logic [bw_psum-1:0]     mag [col];
    logic                   neg [col];
    logic [DW-1:0]          dvd_init [col];
    logic [SW-1:0]          total;

    // Per-lane magnitude; the most negative value maps to 2^(bw_psum-1),
    // which still fits as an unsigned bw_psum-bit number.
    generate
        for (genvar gi = 0; gi < col; gi++) begin : g_lane
            logic [bw_psum-1:0] lane_val;
            assign lane_val      = row_reg[bw_psum*gi +: bw_psum];
            assign neg[gi]       = lane_val[bw_psum-1];
            assign mag[gi]       = neg[gi] ? (~lane_val + 1'b1) : lane_val;
            assign dvd_init[gi]  = {mag[gi], {frac{1'b0}}};
        end
    endgenerate

    always_comb begin
        total = '0;
        for (int i = 0; i < col; i++) begin
            total = total + {4'b0000, mag[i]};
        end
    end

    logic              lane_last, iter_last;
    logic [LANE_W-1:0] lane_nxt;
    assign lane_last = (lane_reg == LANE_W'(col - 1));
    assign iter_last = (iter_reg == ITER_W'(DW - 1));
    assign lane_nxt  = lane_last ? '0 : lane_reg + 1'b1;

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    logic [SW:0]        trial;
    logic               ge;
    logic [SW-1:0]      diff, rem_step;
    logic [bw_psum-1:0] quot_step, lane_res;

    always_comb begin
        trial     = {rem_reg, dvd_reg[DW-1]};
        ge        = (trial >= {1'b0, sum_reg});
        diff      = trial[SW-1:0] - sum_reg;
        rem_step  = ge ? diff : trial[SW-1:0];
        quot_step = {quot_reg[bw_psum-2:0], ge};
        lane_res  = neg[lane_reg] ? (~quot_step + 1'b1) : quot_step;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_next = SUM;
            end
            SUM: begin
                state_next = (total == '0) ? DONE : DIV;
            end
            DIV: begin
                if (iter_last && lane_last) state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_reg  <= '0;
            out_reg  <= '0;
            sum_reg  <= '0;
            lane_reg <= '0;
            iter_reg <= '0;
            dvd_reg  <= '0;
            rem_reg  <= '0;
            quot_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) row_reg <= bus.in;
                end
                SUM: begin
                    // Lane 0 is preloaded here so DIV spends exactly DW cycles per lane.
                    sum_reg  <= total;
                    out_reg  <= '0;
                    lane_reg <= '0;
                    iter_reg <= '0;
                    dvd_reg  <= dvd_init[0];
                    rem_reg  <= '0;
                    quot_reg <= '0;
                end
                DIV: begin
                    if (iter_last) begin
                        out_reg[lane_reg*bw_psum +: bw_psum] <= lane_res;
                        lane_reg <= lane_nxt;
                        iter_reg <= '0;
                        dvd_reg  <= dvd_init[lane_nxt];
                        rem_reg  <= '0;
                        quot_reg <= '0;
                    end else begin
                        iter_reg <= iter_reg + 1'b1;
                        dvd_reg  <= {dvd_reg[DW-2:0], 1'b0};
                        rem_reg  <= rem_step;
                        quot_reg <= quot_step;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum_out = sum_reg;
    assign bus.out     = out_reg;
endmodule

// File: tb/tb_sfp_norm.sv
// Scoreboard bench for sfp_norm: a reference model pushes expected sum/lanes/latency
// when a row is accepted; the entry is popped and compared when out_valid rises.
module tb_sfp_norm;
    localparam int COL = 8;
    localparam int BW  = 20;
    localparam int FR  = 8;
    localparam int RW  = COL * BW;

    typedef struct {
        logic [BW+3:0] sum;
        logic [RW-1:0] out;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   accept_cyc = 0;
    exp_t sb [$];

    sfp_norm_if #(.col(COL), .bw_psum(BW)) bus ();

    sfp_norm #(.col(COL), .bw_psum(BW), .frac(FR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [RW-1:0] pack(input int v [COL]);
        logic [RW-1:0] r;
        r = '0;
        for (int i = 0; i < COL; i++) r[i*BW +: BW] = v[i][BW-1:0];
        return r;
    endfunction

    function automatic exp_t model(input logic [RW-1:0] row);
        exp_t e;
        logic signed [BW-1:0] t;
        longint v [COL];
        longint a [COL];
        longint s, q;
        s = 0;
        for (int i = 0; i < COL; i++) begin
            t = row[i*BW +: BW];
            v[i] = t;
            a[i] = (v[i] < 0) ? -v[i] : v[i];
            s += a[i];
        end
        e.sum = s[BW+3:0];
        e.out = '0;
        for (int i = 0; i < COL; i++) begin
            q = (s == 0) ? 0 : (a[i] * 256) / s;
            if (v[i] < 0) q = -q;
            e.out[i*BW +: BW] = q[BW-1:0];
        end
        e.lat = (s == 0) ? 2 : 2 + COL * (BW + FR);
        return e;
    endfunction

    // Offer a row; when now=1 the caller is already at a negedge.
    task automatic send_row(input logic [RW-1:0] row, input bit now, output int waited);
        waited = 0;
        if (!now) @(negedge clk);
        bus.in = row;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus.in_ready) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%0b required 1", bus.in_ready);
        end
        accept_cyc = cyc;
        sb.push_back(model(row));
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Wait for a result, optionally hold off out_ready, compare, then handshake.
    task automatic get_result(input string name, input int hold, input bit keep_ready);
        exp_t e;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 2000);
        e = sb.pop_front();
        checks++;
        if (!bus.out_valid) begin
            errors++;
            $display("FAIL %s out_valid_timeout out_valid=%0b required 1", name, bus.out_valid);
            return;
        end
        checks++;
        if ((cyc - accept_cyc) !== e.lat) begin
            errors++;
            $display("FAIL %s latency got=%0d required %0d", name, cyc - accept_cyc, e.lat);
        end
        for (int k = 0; k < hold; k++) begin
            bus.in_valid = (k % 2 == 0) && (k < hold - 2);
            bus.in = {COL{20'h00123}};
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.sum_out !== e.sum || bus.out !== e.out) begin
                errors++;
                $display("FAIL %s hold%0d out_valid=%0b in_ready=%0b sum=%0d out=%h required 1 0 %0d %h",
                         name, k, bus.out_valid, bus.in_ready, bus.sum_out, bus.out, e.sum, e.out);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.sum_out !== e.sum) begin
            errors++;
            $display("FAIL %s sum_out got=%0d required %0d", name, bus.sum_out, e.sum);
        end
        for (int i = 0; i < COL; i++) begin
            checks++;
            if (bus.out[i*BW +: BW] !== e.out[i*BW +: BW]) begin
                errors++;
                $display("FAIL %s lane%0d got=%0d required %0d", name, i,
                         $signed(bus.out[i*BW +: BW]), $signed(e.out[i*BW +: BW]));
            end
        end
        $display("%s: sum_out=%0d latency=%0d lane0=%0d lane1=%0d", name, bus.sum_out,
                 cyc - accept_cyc, $signed(bus.out[0 +: BW]), $signed(bus.out[BW +: BW]));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = keep_ready;
    endtask

    task automatic test_reset();
        bus.in = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.sum_out !== '0 || bus.out !== '0) begin
            errors++;
            $display("FAIL reset in_ready=%0b out_valid=%0b sum=%0d out=%h required 1 0 0 0",
                     bus.in_ready, bus.out_valid, bus.sum_out, bus.out);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("reset: in_ready=%0b out_valid=%0b", bus.in_ready, bus.out_valid);
    endtask

    task automatic test_basic();
        int w;
        logic [RW-1:0] r;
        send_row(pack('{3, -1, 0, 0, 0, 0, 0, 0}), 0, w);
        get_result("row_3_m1", 0, 0);
        send_row(pack('{7, 0, 0, 0, 0, 0, 0, 0}), 0, w);
        get_result("row_7", 0, 0);
        send_row(pack('{1, 1, 1, 0, 0, 0, 0, 0}), 0, w);
        get_result("row_111", 0, 0);
        send_row(pack('{default: -524288}), 0, w);
        get_result("row_min", 0, 0);
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < COL; i++) r[i*BW +: BW] = 20'($urandom);
            send_row(r, 0, w);
            get_result("row_rand", 0, 0);
        end
    endtask

    task automatic test_zero();
        int w;
        send_row(pack('{default: 0}), 0, w);
        get_result("row_zero", 0, 0);
    endtask

    task automatic test_backpressure();
        int w;
        send_row(pack('{-5, 2, 9, 0, -1, 3, 0, 100}), 0, w);
        get_result("backpressure", 50, 0);
        send_row(pack('{40, -8, 0, 0, 12, 0, 0, 0}), 0, w);
        get_result("after_release", 0, 0);
    endtask

    task automatic test_reset_mid_div();
        int w;
        send_row(pack('{3, -1, 0, 0, 0, 0, 0, 0}), 0, w);
        repeat (101) @(negedge clk);
        reset = 1'b1;
        #1;
        void'(sb.pop_front());
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.sum_out !== '0 || bus.out !== '0) begin
            errors++;
            $display("FAIL reset_mid_div out_valid=%0b in_ready=%0b sum=%0d out=%h required 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.sum_out, bus.out);
        end
        $display("reset_mid_div: sum_out=%0d in_ready=%0b", bus.sum_out, bus.in_ready);
        @(negedge clk);
        reset = 1'b0;
        send_row(pack('{3, -1, 0, 0, 0, 0, 0, 0}), 0, w);
        get_result("after_reset", 0, 0);
    endtask

    task automatic test_back_to_back();
        int w;
        bus.out_ready = 1'b1;
        send_row(pack('{10, -20, 30, -40, 0, 0, 0, 0}), 0, w);
        get_result("b2b_first", 0, 1);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_turnaround out_valid=%0b in_ready=%0b required 0 1", bus.out_valid, bus.in_ready);
        end
        send_row(pack('{0, 0, 0, 0, 0, 0, 0, -3}), 1, w);
        checks++;
        if (w !== 0) begin
            errors++;
            $display("FAIL b2b_accept wait=%0d required 0", w);
        end
        get_result("b2b_second", 0, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_reset_mid_div();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
